wb_hazard_scoreboard: RTL
=========================

// Module: wb_hazard_scoreboard
// PURPOSE
//  Issue controller for the non-forwarding pipeline. Tracks every instruction between issue (ID->EX) and
//  retirement (WB) in an in-order tag FIFO, and stalls ID on RAW hazards against in-flight writers or when full.
//  Sits beside the ID stage. Its pop side is driven by the writeback stage outputs (rd, wb_en) plus a WB valid bit.
// PARAMETERS
//  DEPTH     3  max in-flight instructions (EX, MEM, WB); legal range 2..8
//  WB_BYPASS 1  1: regfile is write-first, so the entry retiring this cycle does not stall; 0: it still stalls
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_reset        in   1   synchronous reset, active-high
//  i_id_valid     in   1   valid instruction in ID requesting issue
//  i_id_rs1       in   5   source reg 1 index
//  i_id_rs1_used  in   1   instruction reads rs1
//  i_id_rs2       in   5   source reg 2 index
//  i_id_rs2_used  in   1   instruction reads rs2
//  i_id_rd        in   5   destination index
//  i_id_regwen    in   1   instruction writes rd
//  i_flush        in   1   branch/jump redirect: ID contents squashed this cycle
//  i_wb_valid     in   1   a real (non-bubble) instruction retires in WB this cycle
//  i_wb_rd        in   5   rd from writeback stage
//  i_wb_en        in   1   writeback enable from writeback stage
//  o_id_stall     out  1   hold IF/ID, inject bubble into EX
//  o_issue        out  1   instruction issues this cycle (push)
//  o_hazard_rs1   out  1   rs1 RAW hit
//  o_hazard_rs2   out  1   rs2 RAW hit
//  o_count        out  4   occupied entries, 0..DEPTH
//  o_full         out  1   o_count == DEPTH
//  o_empty        out  1   o_count == 0
//  o_err          out  1   sticky protocol error
// BEHAVIOUR
//  - Storage: DEPTH entries {rd[4:0], wen}, with head/tail pointers modulo DEPTH and a count.
//    Entry wen = i_id_regwen && (i_id_rd != 0).
//  - Reset: pointers=0, count=0, all entry wen=0, o_err=0. While i_reset=1: o_issue=0, o_id_stall=0.
//    Reset mid-operation discards all entries.
//  - pop = i_wb_valid && !o_empty. Pops the head entry; head advances with wrap.
//  - Hazard: rsN hits when rsN_used && rsN!=0 && some occupied entry has wen && rd==rsN.
//    The head entry is excluded when (pop && WB_BYPASS).
//  - o_id_stall = i_id_valid && !i_flush && (o_hazard_rs1 || o_hazard_rs2 || (o_full && !pop)).
//  - o_issue = i_id_valid && !i_flush && !o_id_stall. Push at tail on the next edge (zero-cycle decision).
//  - Push and pop in the same cycle: count unchanged; allowed when full (pop frees the slot).
//  - i_flush: no issue and no stall that cycle. Entries already in flight are never squashed.
//  - Hazard outputs are combinational from state and current ID inputs. They are valid even when i_id_valid=0.
//  - Consistency check: on pop, if i_wb_en != head.wen, or (i_wb_en && i_wb_rd != head.rd), set o_err.
//  - Pop request while empty: ignored, set o_err. o_err clears only on reset.
//  - rd=x0 writers never create hazards. Non-writing instructions still occupy slots to keep WB order.
// TESTING
//  1. add x5 issued, then sub x6,x5,x1 in ID -> o_hazard_rs1=1, stall until x5 pops.
//     Issue in pop cycle (BYPASS=1); issue the cycle after (BYPASS=0).
//  2. addi x0 writer followed by a reader of x0 -> no stall. Entry wen=0.
//  3. DEPTH=3, three non-hazard issues with no pops -> o_full=1, 4th stalls.
//     Pop and push in the same cycle -> o_issue=1, o_count stays 3.
//  4. Tail wrap: 10 alternating issue/retire cycles -> pointers wrap, o_count toggles 0/1, o_err=0.
//  5. i_flush=1 with a hazarding ID instruction -> o_id_stall=0, o_issue=0, count unchanged.
//  6. Reset asserted with 2 entries -> o_count=0, o_empty=1 next cycle.
//     Then i_wb_valid while empty -> o_err=1; mismatched i_wb_rd on pop -> o_err=1.

Source files
------------

// File: rtl/wb_hazard_scoreboard.sv
// In-order tag FIFO tracking instructions from issue to writeback; stalls ID on
// RAW hazards against in-flight writers or when every slot is occupied.
module wb_hazard_scoreboard #(
    parameter int unsigned DEPTH     = 3,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic       i_id_rs1_used,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs2_used,
    input  logic [4:0] i_id_rd,
    input  logic       i_id_regwen,
    input  logic       i_flush,
    input  logic       i_wb_valid,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_en,
    output logic       o_id_stall,
    output logic       o_issue,
    output logic       o_hazard_rs1,
    output logic       o_hazard_rs2,
    output logic [3:0] o_count,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PW-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [4:0]       rd_q [DEPTH];
    logic [DEPTH-1:0] wen_q;
    ptr_t             head_q;
    ptr_t             tail_q;
    logic [3:0]       count_q;
    logic             err_q;

    logic pop;
    logic push;
    logic hit_rs1;
    logic hit_rs2;
    logic head_mismatch;

    assign o_count = count_q;
    assign o_empty = (count_q == 4'd0);
    assign o_full  = (count_q == 4'(DEPTH));
    assign o_err   = err_q;
    assign pop     = i_wb_valid && !o_empty;

    // Walk occupied slots oldest-first; the retiring head is skipped when the
    // regfile forwards the write within the same cycle.
    always_comb begin
        ptr_t idx;
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        idx     = head_q;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((k < 32'(count_q)) && !((k == 0) && pop && WB_BYPASS) && wen_q[idx]) begin
                if (rd_q[idx] == i_id_rs1) hit_rs1 = 1'b1;
                if (rd_q[idx] == i_id_rs2) hit_rs2 = 1'b1;
            end
            idx = ptr_inc(idx);
        end
    end

    assign o_hazard_rs1 = i_id_rs1_used && (i_id_rs1 != 5'd0) && hit_rs1;
    assign o_hazard_rs2 = i_id_rs2_used && (i_id_rs2 != 5'd0) && hit_rs2;

    assign o_id_stall = !i_reset && i_id_valid && !i_flush &&
                        (o_hazard_rs1 || o_hazard_rs2 || (o_full && !pop));
    assign o_issue    = !i_reset && i_id_valid && !i_flush && !o_id_stall;
    assign push       = o_issue;

    assign head_mismatch = (i_wb_en != wen_q[head_q]) ||
                           (i_wb_en && (i_wb_rd != rd_q[head_q]));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wen_q   <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) rd_q[i] <= '0;
        end else begin
            if (push) begin
                rd_q[tail_q]  <= i_id_rd;
                wen_q[tail_q] <= i_id_regwen && (i_id_rd != 5'd0);
                tail_q        <= ptr_inc(tail_q);
            end
            if (pop) head_q <= ptr_inc(head_q);
            if (push && !pop)      count_q <= count_q + 4'd1;
            else if (pop && !push) count_q <= count_q - 4'd1;
            if (i_wb_valid && o_empty) err_q <= 1'b1;
            if (pop && head_mismatch)  err_q <= 1'b1;
        end
    end

endmodule
